muldiv_unit: RTL and testbench

- Parametrised iterative multiply/divide unit implementing the RV32M/RV64M operation set.
- Sits beside the single-cycle ALU in the EX stage.
- Accepts one operation through a valid/ready handshake and iterates one bit per cycle.
- Returns the result with a one-cycle completion pulse. Supports pipeline flush and RISC-V-defined divide corner cases.

---
 rtl/muldiv_unit.sv | 167 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M/RV64M multiply/divide unit: one bit per cycle, with a fast path
// for the divide-by-zero and signed-overflow cases.
module muldiv_unit #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            busy,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic            result_zero
);

    localparam int unsigned CNT_W = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

    localparam logic [2:0] OpMul    = 3'b000;
    localparam logic [2:0] OpMulh   = 3'b001;
    localparam logic [2:0] OpMulhsu = 3'b010;
    localparam logic [2:0] OpMulhu  = 3'b011;
    localparam logic [2:0] OpDiv    = 3'b100;
    localparam logic [2:0] OpDivu   = 3'b101;
    localparam logic [2:0] OpRemu   = 3'b111;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0]   opb_q, opb_d;
    logic [2:0]        op_q, op_d;
    logic              qneg_q, qneg_d;
    logic              rneg_q, rneg_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              accept;
    logic              a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic              fast_hit;
    logic [XLEN-1:0]   fast_val;
    logic [XLEN:0]     mul_sum;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] step, prod;
    logic [XLEN-1:0]   quot, rem, fin_val;

    assign in_ready    = ((state_q == StIdle) || (state_q == StDone)) && !flush;
    assign accept      = in_valid && in_ready;
    assign busy        = (state_q == StCalc);
    assign out_valid   = (state_q == StDone);
    assign result      = result_q;
    assign result_zero = (result_q == '0);

    // Operand decode at accept: magnitudes, signs and the no-iteration cases.
    always_comb begin
        a_signed = (op != OpMulhu) && (op != OpDivu) && (op != OpRemu);
        b_signed = a_signed && (op != OpMulhsu);
        a_neg    = a_signed && a[XLEN-1];
        b_neg    = b_signed && b[XLEN-1];
        a_mag    = a_neg ? -a : a;
        b_mag    = b_neg ? -b : b;
        fast_hit = 1'b0;
        fast_val = '0;
        if (op[2]) begin
            if (b == '0) begin
                fast_hit = 1'b1;
                fast_val = op[1] ? a : '1;
            end else if (!op[0] && (a == MinNeg) && (b == '1)) begin
                fast_hit = 1'b1;
                fast_val = op[1] ? '0 : MinNeg;
            end
        end
    end

    // acc_q holds {partial product, multiplier} or {remainder, dividend/quotient}.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        div_ge  = acc_q[2*XLEN-1:XLEN-1] >= {1'b0, opb_q};
        div_rem = acc_q[2*XLEN-2:XLEN-1] - opb_q;
        if (op_q[2]) begin
            step = div_ge ? {div_rem, acc_q[XLEN-2:0], 1'b1} : {acc_q[2*XLEN-2:0], 1'b0};
        end else begin
            step = {mul_sum, acc_q[XLEN-1:1]};
        end
        prod = qneg_q ? -step : step;
        quot = qneg_q ? -step[XLEN-1:0] : step[XLEN-1:0];
        rem  = rneg_q ? -step[2*XLEN-1:XLEN] : step[2*XLEN-1:XLEN];
        case (op_q)
            OpMul:                     fin_val = prod[XLEN-1:0];
            OpMulh, OpMulhsu, OpMulhu: fin_val = prod[2*XLEN-1:XLEN];
            OpDiv, OpDivu:             fin_val = quot;
            default:                   fin_val = rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        op_d     = op_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        case (state_q)
            StIdle: ;
            StCalc: begin
                acc_d = step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    state_d  = StDone;
                    result_d = fin_val;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (accept) begin
            op_d   = op;
            acc_d  = {{XLEN{1'b0}}, a_mag};
            opb_d  = b_mag;
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
            cnt_d  = CNT_W'(XLEN - 1);
            if (fast_hit) begin
                state_d  = StDone;
                result_d = fast_val;
            end else begin
                state_d = StCalc;
            end
        end
        // A kill also discards a completion landing in the same cycle.
        if (flush) begin
            state_d  = StIdle;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            op_q     <= op_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corner cases, flush/reset recovery,
// back-to-back issue and randomized operations against an arithmetic reference.
module tb_muldiv_unit;

    localparam int unsigned XLEN = 32;
    localparam logic [31:0] MinNeg = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        in_ready, busy, out_valid, result_zero;
    logic [31:0] result;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [31:0] exp_hold = 32'd0;

    typedef struct {
        logic [31:0] res;
        int          cyc;
    } exp_t;
    exp_t exp_q[$];

    logic [2:0]  d_op  [11] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd4, 3'd7, 3'd4, 3'd6};
    logic [31:0] d_a   [11] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFEC,
                                32'hFFFF_FFEC, 32'h8000_0000, 32'd5, 32'd5, 32'h8000_0000,
                                32'h8000_0000};
    logic [31:0] d_b   [11] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd3,
                                32'd3, 32'd4, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] d_res [11] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF,
                                32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'h2000_0000, 32'hFFFF_FFFF, 32'd5,
                                32'h8000_0000, 32'd0};

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .op         (op),
        .a          (a),
        .b          (b),
        .flush      (flush),
        .busy       (busy),
        .out_valid  (out_valid),
        .result     (result),
        .result_zero(result_zero)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] x,
                                          input logic [31:0] y);
        longint          sx, sy, p;
        longint unsigned ux, uy, up;
        logic            ovf;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        ux  = {32'd0, x};
        uy  = {32'd0, y};
        ovf = (x == MinNeg) && (y == 32'hFFFF_FFFF);
        case (o)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * longint'(uy); return p[63:32]; end
            3'd3: begin up = ux * uy; return up[63:32]; end
            3'd4: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return MinNeg;
                p = sx / sy;
                return p[31:0];
            end
            3'd5: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                up = ux / uy;
                return up[31:0];
            end
            3'd6: begin
                if (y == 32'd0) return x;
                if (ovf) return 32'd0;
                p = sx % sy;
                return p[31:0];
            end
            default: begin
                if (y == 32'd0) return x;
                up = ux % uy;
                return up[31:0];
            end
        endcase
    endfunction

    // Called at a falling edge; returns one falling edge after the accept.
    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] want, input bit push);
        int guard = 0;
        int lat;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            chk("in_ready_wait", 32'(in_ready), 32'd1);
            return;
        end
        lat = (o[2] && (y == 32'd0 || (!o[0] && x == MinNeg && y == 32'hFFFF_FFFF))) ? 1 : 33;
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        if (push) exp_q.push_back('{want, cyc + lat});
        @(negedge clk);
        in_valid = 1'b0;
        op = 3'($urandom_range(0, 7));
        a = $urandom;
        b = $urandom;
        if (lat == 1) chk("busy_fast_path", 32'(busy), 32'd0);
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("spurious_out_valid", 32'(out_valid), 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("result", result, e.res);
                        chk("latency_cycle", 32'(cyc), 32'(e.cyc));
                        exp_hold = e.res;
                    end
                end else begin
                    chk("result_hold", result, exp_hold);
                end
                chk("result_zero", 32'(result_zero), 32'(exp_hold == 32'd0));
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        logic [2:0]  o;
        logic [31:0] x, y;
        int sel;

        #1 rst = 1'b1;
        #1;
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_result", result, 32'd0);
        chk("reset_result_zero", 32'(result_zero), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 11; i++) issue(d_op[i], d_a[i], d_b[i], d_res[i], 1'b1);
        drain();

        // Flush mid-divide, then flush racing a request in IDLE.
        issue(3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_blocks_ready", 32'(in_ready), 32'd0);
        chk("busy_before_flush", 32'(busy), 32'd1);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_ready", 32'(in_ready), 32'd1);
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_no_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        flush = 1'b1;
        in_valid = 1'b1;
        op = 3'd0;
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_wins_busy", 32'(busy), 32'd0);
        chk("flush_wins_ready", 32'(in_ready), 32'd1);
        issue(3'd0, 32'd6, 32'd7, 32'd42, 1'b1);
        drain();

        // Asynchronous reset mid-divide.
        issue(3'd5, 32'd100, 32'd7, 32'd14, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        exp_hold = 32'd0;
        #1;
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_result", result, 32'd0);
        chk("rst_mid_result_zero", 32'(result_zero), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_recover_ready", 32'(in_ready), 32'd1);
        issue(3'd0, 32'd6, 32'd7, 32'd42, 1'b1);
        drain();

        // Back-to-back: second op accepted in the DONE cycle of the first.
        c0 = cyc;
        issue(3'd0, 32'd3, 32'd5, 32'd15, 1'b1);
        repeat (32) @(negedge clk);
        chk("b2b_done_cycle", 32'(cyc), 32'(c0 + 33));
        chk("b2b_ready_in_done", 32'(in_ready), 32'd1);
        chk("b2b_out_valid", 32'(out_valid), 32'd1);
        issue(3'd5, 32'd9, 32'd2, 32'd4, 1'b1);
        drain();

        for (int i = 0; i < 150; i++) begin
            o = 3'($urandom_range(0, 7));
            x = $urandom;
            y = $urandom;
            sel = int'($urandom_range(0, 9));
            if (sel == 0) y = 32'd0;
            if (sel == 1) begin
                x = MinNeg;
                y = 32'hFFFF_FFFF;
            end
            if (sel == 2) y = 32'($urandom_range(1, 15));
            if (sel == 3) x = 32'($urandom_range(0, 100));
            issue(o, x, y, model(o, x, y), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
